// File: rtl/bsk_com_filter_if.sv
// Command filter bus: raw optocoupler lines in, debounced commands out.
interface bsk_com_filter_if;
  logic [15:0] iComRaw;
  logic        iHold;
  logic [15:0] oCom;
  logic        oUpd;
  logic        oTick;

  modport master (
    output iComRaw,
    output iHold,
    input  oCom,
    input  oUpd,
    input  oTick
  );

  modport slave (
    input  iComRaw,
    input  iHold,
    output oCom,
    output oUpd,
    output oTick
  );
endinterface

// File: rtl/bsk_com_filter.sv
// 16-channel command debouncer: 2-flop sync, tick prescaler and
// per-channel consecutive-tick counters.
module bsk_com_filter #(
  parameter int unsigned CLOCK_IN   = 4_000_000,
  parameter int unsigned TICK_DIV   = 4000,
  parameter int unsigned FILTER_LEN = 5,
  parameter bit          INV        = 1'b1
) (
  input  logic             clk,
  input  logic             iRes,
  bsk_com_filter_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

  if (TICK_DIV < 2 || FILTER_LEN < 1 || CLOCK_IN < TICK_DIV) begin : g_bad_param
    $error("bsk_com_filter: illegal parameter set");
  end

  logic [15:0]   s1;
  logic [15:0]   s2;
  logic [PW-1:0] presc;
  logic          tick;
  logic [CW-1:0] cnt     [16];
  logic [CW-1:0] cnt_nxt [16];
  logic [15:0]   com_nxt;
  logic          upd_nxt;

  assign tick      = (presc == PMAX);
  assign bus.oTick = tick && !iRes;

  always_comb begin
    com_nxt = bus.oCom;
    for (int i = 0; i < 16; i++) cnt_nxt[i] = cnt[i];
    // Counters only move on an unfrozen tick; agreement restarts the run
    if (tick && !bus.iHold) begin
      for (int i = 0; i < 16; i++) begin
        if (s2[i] == bus.oCom[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CMAX) begin
          com_nxt[i] = s2[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
    upd_nxt = |(com_nxt ^ bus.oCom);
  end

  always_ff @(posedge clk) begin
    if (iRes) begin
      s1       <= '0;
      s2       <= '0;
      presc    <= '0;
      bus.oCom <= '0;
      bus.oUpd <= 1'b0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      s1       <= bus.iComRaw ^ {16{INV}};
      s2       <= s1;
      presc    <= tick ? '0 : presc + 1'b1;
      bus.oCom <= com_nxt;
      bus.oUpd <= upd_nxt;
      for (int i = 0; i < 16; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_bsk_com_filter.sv
// Scoreboard bench for bsk_com_filter (TICK_DIV=4, FILTER_LEN=3, INV=1).
module tb_bsk_com_filter;

  localparam int TD = 4;
  localparam int FL = 3;

  logic clk = 1'b0;
  logic iRes;
  bsk_com_filter_if bus ();

  bsk_com_filter #(
    .CLOCK_IN   (4_000_000),
    .TICK_DIV   (TD),
    .FILTER_LEN (FL),
    .INV        (1'b1)
  ) dut (
    .clk  (clk),
    .iRes (iRes),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Every oUpd pulse must match a queued expectation
  always @(negedge clk) begin
    if (!iRes && bus.oUpd === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_upd", {15'd0, bus.oUpd}, 16'd0);
      else chk("sb_com", bus.oCom, exp_q.pop_front());
    end
  end

  // Returns at the negedge of the next cycle with oTick=1
  task automatic sync_tick();
    bit seen = 0;
    for (int k = 0; k < 3 * TD && !seen; k++) begin
      @(negedge clk);
      if (bus.oTick === 1'b1) seen = 1;
    end
    if (!seen) chk("tick_timeout", {15'd0, bus.oTick}, 16'd1);
  endtask

  task automatic expect_change(input string tag, input logic [15:0] raw,
                               input logic [15:0] exp);
    logic [15:0] old;
    old = bus.oCom;
    sync_tick();
    bus.iComRaw = raw;
    exp_q.push_back(exp);
    for (int t = 0; t < FL; t++) begin
      sync_tick();
      chk({tag, "_early"}, bus.oCom, old);
    end
    @(negedge clk);
    chk({tag, "_com"}, bus.oCom, exp);
    chk({tag, "_upd"}, {15'd0, bus.oUpd}, 16'd1);
    @(negedge clk);
    chk({tag, "_upd_off"}, {15'd0, bus.oUpd}, 16'd0);
  endtask

  initial begin
    int n;
    iRes        = 1'b1;
    bus.iComRaw = 16'h0000;
    bus.iHold   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_com", bus.oCom, 16'h0000);
    chk("rst_upd", {15'd0, bus.oUpd}, 16'd0);
    chk("rst_tick", {15'd0, bus.oTick}, 16'd0);

    iRes        = 1'b0;
    bus.iComRaw = 16'hFFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.oTick !== 1'b1 && n < 4 * TD);
    chk("first_tick", 16'(n), 16'(TD - 1));
    for (int t = 0; t < 4; t++) begin
      sync_tick();
      chk("idle_com", bus.oCom, 16'h0000);
    end

    expect_change("stable", 16'hFFF7, 16'h0008);
    expect_change("stable_back", 16'hFFFF, 16'h0000);

    // Two differing ticks then agreement: no update, count restarts
    sync_tick();
    bus.iComRaw = 16'hFFF7;
    sync_tick();
    sync_tick();
    bus.iComRaw = 16'hFFFF;
    for (int t = 0; t < 4; t++) begin
      sync_tick();
      chk("glitch_com", bus.oCom, 16'h0000);
    end
    expect_change("after_glitch", 16'hFFF7, 16'h0008);
    expect_change("glitch_back", 16'hFFFF, 16'h0000);

    expect_change("simul", 16'h7FFE, 16'h8001);
    expect_change("simul_back", 16'hFFFF, 16'h0000);

    // Hold after two differing ticks, release, accept on next tick
    sync_tick();
    bus.iComRaw = 16'hFFDF;
    sync_tick();
    sync_tick();
    @(negedge clk);
    bus.iHold = 1'b1;
    for (int t = 0; t < 5; t++) begin
      sync_tick();
      chk("hold_com", bus.oCom, 16'h0000);
    end
    @(negedge clk);
    bus.iHold = 1'b0;
    exp_q.push_back(16'h0020);
    sync_tick();
    chk("hold_early", bus.oCom, 16'h0000);
    @(negedge clk);
    chk("hold_com_rel", bus.oCom, 16'h0020);
    chk("hold_upd", {15'd0, bus.oUpd}, 16'd1);
    expect_change("hold_back", 16'hFFFF, 16'h0000);

    // Reset mid-count discards partial progress of bit 7
    sync_tick();
    bus.iComRaw = 16'hFF7F;
    sync_tick();
    sync_tick();
    @(negedge clk);
    iRes = 1'b1;
    @(negedge clk);
    chk("mrst_tick", {15'd0, bus.oTick}, 16'd0);
    chk("mrst_upd", {15'd0, bus.oUpd}, 16'd0);
    iRes = 1'b0;
    exp_q.push_back(16'h0080);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.oTick !== 1'b1 && n < 4 * TD);
    chk("mrst_first_tick", 16'(n), 16'(TD - 1));
    chk("mrst_t1", bus.oCom, 16'h0000);
    for (int t = 1; t < FL; t++) begin
      sync_tick();
      chk("mrst_early", bus.oCom, 16'h0000);
    end
    @(negedge clk);
    chk("mrst_com", bus.oCom, 16'h0080);
    chk("mrst_upd_on", {15'd0, bus.oUpd}, 16'd1);
    expect_change("mrst_back", 16'hFFFF, 16'h0000);

    repeat (3 * TD) @(negedge clk);
    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
